alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single clocked ALU between two requesters, e.g. instruction issue and address generation. Each requester presents op/in1/in2 with a valid/ready handshake. The arbiter grants round-robin, holds the operands stable on the ALU inputs for the ALU's latency, and returns the result as a one-cycle response pulse to the granted requester. It has one transaction in flight at a time.

Parameters:
WORD_SIZE, 16, datapath width; taken from the shared parameters include.
ALU_LATENCY, 1, cycles from operands first presented to the ALU until alu_out is valid; must be at least 1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 accepted this cycle.
req0_op  in  3  ALU opcode (ALU_ADD..ALU_SHIFT).
req0_in1, req0_in2  in  WORD_SIZE  operands.
resp0_valid  out  1  one-cycle result pulse for requester 0.
resp0_data  out  WORD_SIZE  result.
req1_valid / req1_ready / req1_op / req1_in1 / req1_in2 / resp1_valid / resp1_data: same as requester 0, for requester 1.
alu_op  out  3  opcode to the ALU.
alu_in1, alu_in2  out  WORD_SIZE  operands to the ALU.
alu_out  in  WORD_SIZE  result from the ALU.

Behaviour:
- Reset (asynchronous) values:
  - state IDLE; last_grant=1, so requester 0 wins the first tie.
  - All readies and resp_valids are 0; resp_data is 0.
  - alu_op=ALU_ADD; alu_in1 and alu_in2 are 0.
- States and transitions:
  - IDLE -> BUSY on an accept.
  - BUSY -> DONE when the latency counter expires.
  - DONE -> IDLE unconditionally.
- Accept, cycle 0:
  - Happens only in IDLE.
  - reqN_ready is combinational and high only when state==IDLE and N is the grant winner.
  - Ready may depend on valid. Valid must not depend on ready.
  - The transfer occurs when valid&&ready at a rising edge. That edge latches op/in1/in2 into operand registers, records the grant id and loads counter=ALU_LATENCY.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the one not equal to last_grant wins.
  - last_grant updates on every accept.
- BUSY, cycles 1..ALU_LATENCY:
  - alu_op/alu_in1/alu_in2 are driven from the operand registers and stay stable until the next accept.
  - The counter decrements each cycle.
- DONE, cycle ALU_LATENCY+1:
  - alu_out is valid and is registered into the granted requester's resp_data at the end of the cycle.
- Response, cycle ALU_LATENCY+2:
  - respN_valid=1 for exactly one cycle; the other resp_valid stays 0.
  - The FSM is already IDLE in this cycle, so a new accept may coincide with the response.
- Timing summary:
  - Accept-to-response latency is ALU_LATENCY+2 cycles.
  - Peak throughput is one op per ALU_LATENCY+2 cycles.
- resp_data holds its last value until overwritten by that requester's next result.
- Opcodes pass through unchanged. All 8 encodings are legal and no opcode checking is done.
- Reset mid-transaction: the in-flight op is dropped, no response is issued, and the FSM returns to IDLE with last_grant=1.
- A requester dropping valid before ready is legal; nothing is latched.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN
- Defined: fixed priority; requester 0 always wins when both are valid, and last_grant is unused.
- Undefined (default): round-robin as above.
- Timing and handshake are identical in both cases.

Decomposition:
- The shared parameters include file holds WORD_SIZE, the ALU_* opcodes and the arbiter state encodings (ARB_IDLE, ARB_BUSY, ARB_DONE).
- One sub-module, alu_arb_pick: combinational 2-way picker (valid0, valid1, last_grant) -> (grant_valid, grant_id). It also contains the ALU_ARB_FIXED_PRIO_EN variant.

Test Plan:
1. req0 ADD 5,7 alone -> req0_ready in cycle 0; resp0_valid in cycle 3 with data 12; resp1_valid stays 0.
2. After reset, req0 SUB 15,4 and req1 MUL 4,9 valid together -> req0 accepted cycle 0, resp0=11 in cycle 3; req1 accepted cycle 3, resp1=36 in cycle 6.
3. Both held valid continuously with AND 9,12 / OR 9,12 -> grants alternate 0,1,0,1; results 8,13,8,13. With ALU_ARB_FIXED_PRIO_EN, all grants go to 0.
4. req1 XOR 9,12 accepted, reset pulsed in cycle 2 -> no resp1_valid. Then req1 SLT 5,7 -> resp1 valid with data 1, three cycles after its accept.
5. ALU_LATENCY=2 with a 2-stage ALU model, req0 SHIFT 5,3 -> alu_in1 and alu_in2 stable cycles 1-3; resp0=40 in cycle 4.
6. req0 valid for 1 cycle while busy, then dropped -> never accepted; no resp0_valid.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: datapath width, ALU opcodes and arbiter state encodings.
package alu_arbiter_pkg;

  localparam int WORD_SIZE = 16;
  localparam int NUM_REQ   = 2;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_MUL   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_XOR   = 3'd5;
  localparam logic [2:0] ALU_SLT   = 3'd6;
  localparam logic [2:0] ALU_SHIFT = 3'd7;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational two-way grant picker: round-robin by default, fixed priority to
// requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_arb_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = valid0 | valid1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant_id = ~valid0 & valid1;
`else
    // On a tie the requester that did not win last time goes first.
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = valid1;
    end
`endif
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between two valid/ready requesters, one transaction in flight.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [2:0]           req0_op,
  input  logic [WORD_SIZE-1:0] req0_in1,
  input  logic [WORD_SIZE-1:0] req0_in2,
  output logic                 resp0_valid,
  output logic [WORD_SIZE-1:0] resp0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [2:0]           req1_op,
  input  logic [WORD_SIZE-1:0] req1_in1,
  input  logic [WORD_SIZE-1:0] req1_in2,
  output logic                 resp1_valid,
  output logic [WORD_SIZE-1:0] resp1_data,
  output logic [2:0]           alu_op,
  output logic [WORD_SIZE-1:0] alu_in1,
  output logic [WORD_SIZE-1:0] alu_in2,
  input  logic [WORD_SIZE-1:0] alu_out
);

  localparam int               CNT_W    = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  arb_state_t           state_reg, state_next;
  logic                 last_grant_reg;
  logic                 grant_id_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [2:0]           op_reg;
  logic [WORD_SIZE-1:0] in1_reg, in2_reg;

  logic                 grant_valid, grant_id, accept;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [WORD_SIZE-1:0] resp_data [NUM_REQ];

  alu_arb_pick u_pick (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: if (accept) state_next = ARB_BUSY;
      ARB_BUSY: if (cnt_reg == CNT_LAST) state_next = ARB_DONE;
      ARB_DONE: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // Ready is offered only to the current winner while idle.
  always_comb begin
    accept    = 1'b0;
    req_ready = '0;
    if (state_reg == ARB_IDLE && grant_valid) begin
      accept              = 1'b1;
      req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
      grant_id_reg   <= 1'b0;
      cnt_reg        <= '0;
      op_reg         <= ALU_ADD;
      in1_reg        <= '0;
      in2_reg        <= '0;
    end else if (accept) begin
      last_grant_reg <= grant_id;
      grant_id_reg   <= grant_id;
      cnt_reg        <= CNT_LOAD;
      op_reg         <= grant_id ? req1_op  : req0_op;
      in1_reg        <= grant_id ? req1_in1 : req0_in1;
      in2_reg        <= grant_id ? req1_in2 : req0_in2;
    end else if (state_reg == ARB_BUSY) begin
      cnt_reg <= cnt_reg - CNT_LAST;
    end
  end

  // Each requester owns its response register; only the granted one captures alu_out.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
    logic                 hit;
    logic                 valid_reg;
    logic [WORD_SIZE-1:0] data_reg;

    assign hit = (state_reg == ARB_DONE) && (grant_id_reg == 1'(gi));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else begin
        valid_reg <= hit;
        if (hit) data_reg <= alu_out;
      end
    end

    assign resp_valid[gi] = valid_reg;
    assign resp_data[gi]  = data_reg;
  end

  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];
  assign resp0_valid = resp_valid[0];
  assign resp1_valid = resp_valid[1];
  assign resp0_data  = resp_data[0];
  assign resp1_data  = resp_data[1];
  assign alu_op      = op_reg;
  assign alu_in1     = in1_reg;
  assign alu_in2     = in2_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one-cycle ALU instance plus a two-cycle ALU instance.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req0_valid, req0_ready, resp0_valid;
  logic [2:0]           req0_op;
  logic [WORD_SIZE-1:0] req0_in1, req0_in2, resp0_data;
  logic                 req1_valid, req1_ready, resp1_valid;
  logic [2:0]           req1_op;
  logic [WORD_SIZE-1:0] req1_in1, req1_in2, resp1_data;
  logic [2:0]           alu_op;
  logic [WORD_SIZE-1:0] alu_in1, alu_in2, alu_out;

  logic                 d2_req0_valid, d2_req0_ready, d2_resp0_valid;
  logic                 d2_req1_valid, d2_req1_ready, d2_resp1_valid;
  logic [WORD_SIZE-1:0] d2_resp0_data, d2_resp1_data;
  logic [2:0]           d2_alu_op;
  logic [WORD_SIZE-1:0] d2_alu_in1, d2_alu_in2, d2_alu_out, d2_stage;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.ALU_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out)
  );

  alu_arbiter #(.ALU_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .req0_valid(d2_req0_valid), .req0_ready(d2_req0_ready), .req0_op(req0_op),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .resp0_valid(d2_resp0_valid), .resp0_data(d2_resp0_data),
    .req1_valid(d2_req1_valid), .req1_ready(d2_req1_ready), .req1_op(req1_op),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .resp1_valid(d2_resp1_valid), .resp1_data(d2_resp1_data),
    .alu_op(d2_alu_op), .alu_in1(d2_alu_in1), .alu_in2(d2_alu_in2), .alu_out(d2_alu_out)
  );

  function automatic logic [WORD_SIZE-1:0] alu_f(input logic [2:0] op,
                                                  input logic [WORD_SIZE-1:0] a,
                                                  input logic [WORD_SIZE-1:0] b);
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_MUL:   return a * b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      default:   return a << b[3:0];
    endcase
  endfunction

  // Behavioural ALUs: one register stage and two register stages.
  always_ff @(posedge clk) alu_out <= alu_f(alu_op, alu_in1, alu_in2);
  always_ff @(posedge clk) begin
    d2_stage   <= alu_f(d2_alu_op, d2_alu_in1, d2_alu_in2);
    d2_alu_out <= d2_stage;
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int g, pg;
    reset = 1'b1;
    req0_valid = 1'b0; req0_op = ALU_ADD; req0_in1 = '0; req0_in2 = '0;
    req1_valid = 1'b0; req1_op = ALU_ADD; req1_in1 = '0; req1_in2 = '0;
    d2_req0_valid = 1'b0; d2_req1_valid = 1'b0;

    go(); go(); smp();
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
    chk("rst_resp0_valid", 32'(resp0_valid), 0);
    chk("rst_resp1_valid", 32'(resp1_valid), 0);
    chk("rst_resp0_data", 32'(resp0_data), 0);
    chk("rst_resp1_data", 32'(resp1_data), 0);
    chk("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    chk("rst_alu_in1", 32'(alu_in1), 0);
    chk("rst_alu_in2", 32'(alu_in2), 0);
    go(); reset = 1'b0;

    // Test 1: req0 ADD 5,7 alone
    go(); req0_valid = 1'b1; req0_op = ALU_ADD; req0_in1 = 16'd5; req0_in2 = 16'd7;
    smp(); chk("t1_ready0", 32'(req0_ready), 1); chk("t1_ready1", 32'(req1_ready), 0);
    go(); req0_valid = 1'b0;
    smp(); chk("t1_alu_in1", 32'(alu_in1), 5); chk("t1_alu_in2", 32'(alu_in2), 7);
    chk("t1_c1_resp0", 32'(resp0_valid), 0);
    go(); smp(); chk("t1_c2_resp0", 32'(resp0_valid), 0);
    go(); smp();
    chk("t1_resp0_valid", 32'(resp0_valid), 1); chk("t1_resp0_data", 32'(resp0_data), 12);
    chk("t1_resp1_valid", 32'(resp1_valid), 0);
    go(); smp();
    chk("t1_c4_resp0", 32'(resp0_valid), 0); chk("t1_hold_data", 32'(resp0_data), 12);

    // Test 2: reset, then both requesters valid together
    go(); reset = 1'b1; #2; reset = 1'b0;
    go();
    req0_valid = 1'b1; req0_op = ALU_SUB; req0_in1 = 16'd15; req0_in2 = 16'd4;
    req1_valid = 1'b1; req1_op = ALU_MUL; req1_in1 = 16'd4;  req1_in2 = 16'd9;
    smp(); chk("t2_ready0", 32'(req0_ready), 1); chk("t2_ready1", 32'(req1_ready), 0);
    go(); req0_valid = 1'b0;
    smp(); chk("t2_c1_ready1", 32'(req1_ready), 0); chk("t2_alu_op_sub", 32'(alu_op), 32'(ALU_SUB));
    go(); smp(); chk("t2_c2_ready1", 32'(req1_ready), 0);
    go(); smp();
    chk("t2_resp0_valid", 32'(resp0_valid), 1); chk("t2_resp0_data", 32'(resp0_data), 11);
    chk("t2_c3_ready1", 32'(req1_ready), 1);
    go(); req1_valid = 1'b0;
    smp(); chk("t2_alu_op_mul", 32'(alu_op), 32'(ALU_MUL)); chk("t2_alu_in1", 32'(alu_in1), 4);
    go(); smp();
    go(); smp();
    chk("t2_resp1_valid", 32'(resp1_valid), 1); chk("t2_resp1_data", 32'(resp1_data), 36);
    chk("t2_c6_resp0", 32'(resp0_valid), 0);

    // Test 3: both held valid; grants alternate (or stay on 0 with fixed priority)
    go();
    req0_valid = 1'b1; req0_op = ALU_AND; req0_in1 = 16'd9; req0_in2 = 16'd12;
    req1_valid = 1'b1; req1_op = ALU_OR;  req1_in1 = 16'd9; req1_in2 = 16'd12;
    pg = 0;
    for (int k = 0; k < 4; k++) begin
      smp();
      g = FIXED ? 0 : (k % 2);
      chk($sformatf("t3_k%0d_ready0", k), 32'(req0_ready), 32'(g == 0));
      chk($sformatf("t3_k%0d_ready1", k), 32'(req1_ready), 32'(g == 1));
      if (k > 0) begin
        if (pg == 0) chk($sformatf("t3_k%0d_resp0", k), {31'd0, resp0_valid} + 32'(resp0_data), 1 + 8);
        else         chk($sformatf("t3_k%0d_resp1", k), {31'd0, resp1_valid} + 32'(resp1_data), 1 + 13);
      end
      pg = g;
      go(); go(); go();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    smp();
    if (pg == 0) chk("t3_last_resp0", {31'd0, resp0_valid} + 32'(resp0_data), 1 + 8);
    else         chk("t3_last_resp1", {31'd0, resp1_valid} + 32'(resp1_data), 1 + 13);

    // Test 4: reset mid-transaction drops the response
    go(); req1_valid = 1'b1; req1_op = ALU_XOR; req1_in1 = 16'd9; req1_in2 = 16'd12;
    smp(); chk("t4_ready1", 32'(req1_ready), 1); chk("t4_ready0", 32'(req0_ready), 0);
    go(); req1_valid = 1'b0; smp();
    go(); reset = 1'b1; #2; reset = 1'b0;
    smp(); chk("t4_rst_resp1_data", 32'(resp1_data), 0);
    go(); smp(); chk("t4_c3_resp1", 32'(resp1_valid), 0);
    go(); smp(); chk("t4_c4_resp1", 32'(resp1_valid), 0); chk("t4_alu_in1", 32'(alu_in1), 0);
    go(); req1_valid = 1'b1; req1_op = ALU_SLT; req1_in1 = 16'd5; req1_in2 = 16'd7;
    smp(); chk("t4_slt_ready1", 32'(req1_ready), 1);
    go(); req1_valid = 1'b0; smp();
    go(); smp(); chk("t4_slt_c2_resp1", 32'(resp1_valid), 0);
    go(); smp();
    chk("t4_slt_resp1_valid", 32'(resp1_valid), 1); chk("t4_slt_resp1_data", 32'(resp1_data), 1);

    // Test 5: ALU_LATENCY=2, SHIFT 5,3
    go(); d2_req0_valid = 1'b1; req0_op = ALU_SHIFT; req0_in1 = 16'd5; req0_in2 = 16'd3;
    smp(); chk("t5_ready0", 32'(d2_req0_ready), 1);
    go(); d2_req0_valid = 1'b0; req0_in1 = 16'hFFFF; req0_in2 = 16'h00FF;
    for (int c = 1; c <= 3; c++) begin
      smp();
      chk($sformatf("t5_c%0d_in1", c), 32'(d2_alu_in1), 5);
      chk($sformatf("t5_c%0d_in2", c), 32'(d2_alu_in2), 3);
      chk($sformatf("t5_c%0d_resp0", c), 32'(d2_resp0_valid), 0);
      go();
    end
    smp();
    chk("t5_resp0_valid", 32'(d2_resp0_valid), 1); chk("t5_resp0_data", 32'(d2_resp0_data), 40);
    chk("t5_alu_op", 32'(d2_alu_op), 32'(ALU_SHIFT));

    // Test 6: req0 valid for one cycle while busy is never accepted
    go(); req1_valid = 1'b1; req1_op = ALU_ADD; req1_in1 = 16'd1; req1_in2 = 16'd1;
    smp(); chk("t6_ready1", 32'(req1_ready), 1);
    go(); req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_in1 = 16'd2; req0_in2 = 16'd2;
    smp(); chk("t6_busy_ready0", 32'(req0_ready), 0);
    go(); req0_valid = 1'b0; smp(); chk("t6_c2_ready0", 32'(req0_ready), 0);
    go(); smp();
    chk("t6_resp1_valid", 32'(resp1_valid), 1); chk("t6_resp1_data", 32'(resp1_data), 2);
    chk("t6_c3_resp0", 32'(resp0_valid), 0);
    for (int c = 4; c <= 6; c++) begin
      go(); smp();
      chk($sformatf("t6_c%0d_resp0", c), 32'(resp0_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
